// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcode values, FSM state codes and instruction classes
package multicycle_control_pkg;
  localparam int OP_ADD  = 1;
  localparam int OP_SUB  = 2;
  localparam int OP_AND  = 3;
  localparam int OP_OR   = 4;
  localparam int OP_ADDI = 5;
  localparam int OP_ANDI = 6;
  localparam int OP_ORI  = 7;
  localparam int OP_LDI  = 8;
  localparam int OP_BEQ  = 9;
  localparam int OP_LD   = 10;
  localparam int OP_STR  = 11;
  localparam int OP_JUMP = 12;
  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_RF       = 4'd1,
    S_IMM_INJ  = 4'd2,
    S_ALU_R3   = 4'd3,
    S_ALU_RI3  = 4'd4,
    S_ALU_4    = 4'd5,
    S_BRANCH3  = 4'd6,
    S_MEM_REF3 = 4'd7,
    S_LOAD4    = 4'd8,
    S_STORE4   = 4'd9,
    S_LOAD5    = 4'd10,
    S_JUMP3    = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;
  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_ALU_R, CLS_ALU_I, CLS_LDI, CLS_BEQ, CLS_LD, CLS_STR, CLS_JUMP
  } cls_t;
endpackage

// File: rtl/multicycle_control_decode.sv
// opcode_class_decode: maps an opcode onto its instruction class
module opcode_class_decode
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output cls_t                cls
);
  always_comb
    cls = opcode inside {OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND), OPCODE_W'(OP_OR)} ? CLS_ALU_R :
          opcode inside {OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI), OPCODE_W'(OP_ORI)} ? CLS_ALU_I :
          opcode == OPCODE_W'(OP_LDI)  ? CLS_LDI  :
          opcode == OPCODE_W'(OP_BEQ)  ? CLS_BEQ  :
          opcode == OPCODE_W'(OP_LD)   ? CLS_LD   :
          opcode == OPCODE_W'(OP_STR)  ? CLS_STR  :
          opcode == OPCODE_W'(OP_JUMP) ? CLS_JUMP : CLS_ILLEGAL;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control FSM with opcode latch and retired-instruction counter
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int CNT_W       = 16,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                hold,
  output logic [3:0]          state,
  output logic                mem_req,
  output logic                mem_we,
  output logic                instr_done,
  output logic                trap,
  output logic [CNT_W-1:0]    instr_count
);
  state_t st, nxt;
  cls_t cls;
  logic [OPCODE_W-1:0] op_q, dec_op;
  logic rdy, term;
  // IF classifies the live opcode; every later state sees only the latched copy
  assign dec_op = st == S_IF ? opcode : op_q;
  opcode_class_decode #(.OPCODE_W(OPCODE_W)) u_dec (.opcode(dec_op), .cls(cls));
  assign rdy = MEM_WAIT_EN != 0 ? mem_ready : 1'b1;
  always_comb begin
    nxt = S_IF;
    case (st)
      S_IF:       nxt = !rdy ? S_IF : cls == CLS_LDI ? S_IMM_INJ : cls == CLS_ILLEGAL ? S_ILLEGAL : S_RF;
      S_RF:       nxt = cls == CLS_ALU_R ? S_ALU_R3 : cls == CLS_ALU_I ? S_ALU_RI3 :
                        cls == CLS_BEQ ? S_BRANCH3 : cls == CLS_JUMP ? S_JUMP3 : S_MEM_REF3;
      S_ALU_R3:   nxt = S_ALU_4;
      S_ALU_RI3:  nxt = S_ALU_4;
      S_MEM_REF3: nxt = cls == CLS_LD ? S_LOAD4 : S_STORE4;
      S_LOAD4:    nxt = rdy ? S_LOAD5 : S_LOAD4;
      S_STORE4:   nxt = rdy ? S_IF : S_STORE4;
      S_ILLEGAL:  nxt = S_ILLEGAL;
      default:    nxt = S_IF;
    endcase
  end
  assign term = st inside {S_IMM_INJ, S_ALU_4, S_BRANCH3, S_STORE4, S_LOAD5, S_JUMP3};
  assign instr_done = term && nxt == S_IF && !hold;
  assign state = st;
  assign mem_req = st inside {S_IF, S_LOAD4, S_STORE4};
  assign mem_we = st == S_STORE4;
  assign trap = st == S_ILLEGAL;
  always_ff @(posedge clk)
    if (rst) begin
      st <= S_IF;
      op_q <= '0;
      instr_count <= '0;
    end else if (!hold) begin
      st <= nxt;
      if (st == S_IF && rdy) op_q <= opcode;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scenarios plus randomized run against an instruction-path model
module tb_multicycle_control;
  import multicycle_control_pkg::*;
  logic clk = 0, rst = 1, hold = 0, mem_ready = 1;
  logic [5:0] opcode = 6'(OP_ADD);
  logic [3:0] state, state2;
  logic mem_req, mem_we, instr_done, trap, mem_req2, mem_we2, instr_done2, trap2;
  logic [15:0] instr_count;
  logic [1:0] instr_count2;
  int checks = 0, errors = 0;
  int m_st = 0;
  int m_path[$];
  logic [15:0] m_cnt = 0;

  multicycle_control dut (.clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .hold(hold),
    .state(state), .mem_req(mem_req), .mem_we(mem_we), .instr_done(instr_done), .trap(trap),
    .instr_count(instr_count));
  multicycle_control #(.CNT_W(2), .MEM_WAIT_EN(0)) dut2 (.clk(clk), .rst(rst), .opcode(opcode),
    .mem_ready(mem_ready), .hold(hold), .state(state2), .mem_req(mem_req2), .mem_we(mem_we2),
    .instr_done(instr_done2), .trap(trap2), .instr_count(instr_count2));

  always #5 clk = ~clk;

  // an instruction is the list of states it visits after IF; falling off the end retires it
  function automatic void load_path(int op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: m_path = '{1, 3, 5};
      OP_ADDI, OP_ANDI, OP_ORI:      m_path = '{1, 4, 5};
      OP_LDI:                        m_path = '{2};
      OP_BEQ:                        m_path = '{1, 6};
      OP_JUMP:                       m_path = '{1, 11};
      OP_LD:                         m_path = '{1, 7, 8, 10};
      OP_STR:                        m_path = '{1, 7, 9};
      default:                       m_path = '{12};
    endcase
  endfunction

  function automatic bit m_stall();
    return (m_st inside {0, 8, 9}) && !mem_ready;
  endfunction

  function automatic bit exp_done();
    return !hold && !(m_st inside {0, 12}) && m_path.size() == 0 && !m_stall();
  endfunction

  task automatic set_in(input logic h, input logic mr, input logic [5:0] op, input logic r);
    hold = h; mem_ready = mr; opcode = op; rst = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_path.delete(); m_cnt = 0;
    end else if (!hold && m_st != 12 && !m_stall()) begin
      if (m_st == 0) load_path(int'(opcode));
      if (m_path.size() == 0) begin
        m_st = 0; m_cnt++;
      end else m_st = m_path.pop_front();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_in(1, 0, 6'(OP_LD), 1);
    step();
    set_in(0, 1, 6'(OP_ADD), 1);
    checks++;
    if ({state, mem_req, mem_we, instr_done, trap, instr_count, instr_count2} !== {4'd0, 4'b1000, 16'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset: state=%0d req=%b we=%b done=%b trap=%b cnt=%0d cnt2=%0d want 0 1 0 0 0 0 0",
        state, mem_req, mem_we, instr_done, trap, instr_count, instr_count2);
    end
    step();
  endtask

  task automatic test_add();
    int seq[4] = '{0, 1, 3, 5};
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 6'(OP_ADD), 0);
      checks++;
      if ({state, instr_done} !== {4'(seq[i]), i == 3}) begin
        errors++;
        $display("FAIL add_seq[%0d]: state=%0d done=%b want %0d %b", i, state, instr_done, seq[i], i == 3);
      end
      step();
    end
    checks++;
    if ({state, instr_count} !== {4'd0, 16'd1}) begin
      errors++;
      $display("FAIL add_end: state=%0d cnt=%0d want 0 1", state, instr_count);
    end
  endtask

  task automatic test_ld();
    int seq[7] = '{0, 1, 7, 8, 8, 8, 10};
    logic mr[7] = '{1, 1, 1, 0, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      set_in(0, mr[i], 6'(OP_LD), 0);
      checks++;
      if ({state, mem_req} !== {4'(seq[i]), seq[i] == 0 || seq[i] == 8}) begin
        errors++;
        $display("FAIL ld_seq[%0d]: state=%0d req=%b want %0d", i, state, mem_req, seq[i]);
      end
      step();
    end
    checks++;
    if ({state, instr_count} !== {4'd0, 16'd2}) begin
      errors++;
      $display("FAIL ld_end: state=%0d cnt=%0d want 0 2", state, instr_count);
    end
  endtask

  task automatic test_str_latch();
    int seq[4] = '{0, 1, 7, 9};
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, i == 0 ? 6'(OP_STR) : 6'(OP_JUMP), 0);
      checks++;
      if ({state, mem_we} !== {4'(seq[i]), seq[i] == 9}) begin
        errors++;
        $display("FAIL str_seq[%0d]: state=%0d we=%b want %0d %b", i, state, mem_we, seq[i], seq[i] == 9);
      end
      step();
    end
    checks++;
    if ({state, mem_we, instr_count} !== {4'd0, 1'b0, 16'd3}) begin
      errors++;
      $display("FAIL str_end: state=%0d we=%b cnt=%0d want 0 0 3", state, mem_we, instr_count);
    end
  endtask

  task automatic test_illegal();
    set_in(0, 1, 6'h3F, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom), 0);
      checks++;
      if ({state, trap, mem_req, instr_done} !== {4'd12, 3'b100}) begin
        errors++;
        $display("FAIL illegal[%0d]: state=%0d trap=%b req=%b done=%b want 12 1 0 0",
          i, state, trap, mem_req, instr_done);
      end
      step();
    end
    set_in(1, 1, 6'(OP_ADD), 1);
    step();
    set_in(0, 1, 6'(OP_ADD), 0);
    checks++;
    if ({state, trap, instr_count} !== {4'd0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL illegal_rst: state=%0d trap=%b cnt=%0d want 0 0 0", state, trap, instr_count);
    end
  endtask

  task automatic test_hold();
    int seq[7] = '{0, 1, 3, 3, 3, 3, 5};
    logic h[7] = '{0, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      set_in(h[i], 1, 6'(OP_ADD), 0);
      checks++;
      if ({state, instr_done} !== {4'(seq[i]), i == 6}) begin
        errors++;
        $display("FAIL hold_seq[%0d]: state=%0d done=%b want %0d %b", i, state, instr_done, seq[i], i == 6);
      end
      step();
    end
    checks++;
    if ({state, instr_count} !== {4'd0, 16'd1}) begin
      errors++;
      $display("FAIL hold_end: state=%0d cnt=%0d want 0 1", state, instr_count);
    end
  endtask

  task automatic test_cnt_wrap();
    set_in(0, 1, 6'(OP_LDI), 1);
    step();
    for (int k = 1; k <= 5; k++) begin
      set_in(0, 1, 6'(OP_LDI), 0);
      step();
      step();
      checks++;
      if ({instr_count2, instr_count} !== {2'(k % 4), 16'(k)}) begin
        errors++;
        $display("FAIL wrap[%0d]: cnt2=%0d cnt=%0d want %0d %0d", k, instr_count2, instr_count, k % 4, k);
      end
    end
    set_in(0, 1, 6'(OP_LD), 0);
    step(); step(); step();
    set_in(0, 0, 6'(OP_LD), 1);
    checks++;
    if ({state, state2} !== {4'd8, 4'd8}) begin
      errors++;
      $display("FAIL wrap_ld4: state=%0d state2=%0d want 8 8", state, state2);
    end
    step();
    set_in(0, 0, 6'(OP_LDI), 0);
    checks++;
    if ({state, state2, instr_count2} !== {4'd0, 4'd0, 2'd0}) begin
      errors++;
      $display("FAIL rst_ld4: state=%0d state2=%0d cnt2=%0d want 0 0 0", state, state2, instr_count2);
    end
    step();
    checks++;
    if ({state, state2} !== {4'd0, 4'd2}) begin
      errors++;
      $display("FAIL nowait: state=%0d state2=%0d want 0 2", state, state2);
    end
    set_in(0, 1, 6'(OP_LDI), 1);
    step();
  endtask

  task automatic test_random();
    int ops[12] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_BEQ, OP_LD, OP_STR, OP_JUMP};
    logic [23:0] exp;
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7,
        $urandom_range(0, 39) == 0 ? 6'($urandom_range(13, 63)) : 6'(ops[$urandom_range(0, 11)]),
        m_st == 12 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 99) == 0);
      exp = {4'(m_st), m_st == 0 || m_st == 8 || m_st == 9, m_st == 9, m_st == 12, exp_done(), m_cnt};
      checks++;
      if ({state, mem_req, mem_we, trap, instr_done, instr_count} !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got st=%0d req/we/trap/done=%b cnt=%0d want st=%0d %b cnt=%0d", i,
          state, {mem_req, mem_we, trap, instr_done}, instr_count, exp[23:20], exp[19:16], exp[15:0]);
      end
      step();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_ld();
    test_str_latch();
    test_illegal();
    test_hold();
    test_cnt_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6: opcode field width.
REQ-002 SHALL have parameter CNT_W, default 16: retired-instruction counter width.
REQ-003 SHALL have parameter MEM_WAIT_EN, default 1: when 1, memory states wait on mem_ready; when 0, mem_ready is ignored and treated as 1.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port opcode  input  OPCODE_W  instruction opcode; sampled only in IF.
REQ-007 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-008 SHALL have port hold  input  1  freeze FSM, latched opcode and counter this cycle.
REQ-009 SHALL have port state  output  4  current FSM state code.
REQ-010 SHALL have port mem_req  output  1  memory access request.
REQ-011 SHALL have port mem_we  output  1  memory write qualifier.
REQ-012 SHALL have port instr_done  output  1  one-cycle pulse on instruction retirement.
REQ-013 SHALL have port trap  output  1  sticky illegal-opcode flag.
REQ-014 SHALL have port instr_count  output  CNT_W  retired-instruction count.

Function
REQ-015 SHALL encode states IF=0, RF=1, IMM_INJ=2, ALU_R3=3, ALU_RI3=4, ALU_4=5, BRANCH3=6, MEM_REF3=7, LOAD4=8, STORE4=9, LOAD5=10, JUMP3=11, ILLEGAL=12; codes 13-15 are unreachable and SHALL return to IF on the next edge.
REQ-016 SHALL, when leaving IF, latch opcode into an internal register; RF and all later states SHALL decode only the latched value.
REQ-017 IF SHALL go to IMM_INJ for LDI, to ILLEGAL for any opcode outside the supported set, and to RF otherwise.
REQ-018 IF SHALL wait for mem_ready before leaving.
REQ-019 RF SHALL go to ALU_R3 for R-type ALU opcodes, ALU_RI3 for ADDI-class, BRANCH3 for BEQ, MEM_REF3 for LD/STR, and JUMP3 for JUMP.
REQ-020 ALU_R3 and ALU_RI3 SHALL go to ALU_4; MEM_REF3 SHALL go to LOAD4 for LD and STORE4 for STR; LOAD4 SHALL go to LOAD5.
REQ-021 LOAD4 and STORE4 SHALL remain in place until mem_ready is high.
REQ-022 IMM_INJ, ALU_4, BRANCH3, STORE4, LOAD5 and JUMP3 SHALL return to IF.
REQ-023 Nominal latencies with mem_ready held high SHALL be: LDI 2, BEQ/JUMP 3, ALU/STR 4, LD 5 cycles, each counted from entry to IF until re-entry to IF.
REQ-024 mem_req SHALL be 1 in IF, LOAD4 and STORE4, and 0 otherwise; mem_we SHALL be 1 only in STORE4.
REQ-025 instr_done SHALL be high in the cycle a terminal state (REQ-022) advances to IF, and only then.
REQ-026 instr_count SHALL increment by 1 at the edge ending each instr_done cycle, wrapping from 2^CNT_W-1 to 0 with no flag.
REQ-027 ILLEGAL SHALL hold trap=1, mem_req=0 and instr_done=0, and SHALL be left only through rst.
REQ-028 When hold=1, state, latched opcode and instr_count SHALL be unchanged for that cycle, instr_done SHALL be 0, and mem_req/mem_we SHALL still reflect the current state.
REQ-029 hold=1 SHALL take priority over mem_ready=1 in the same cycle, meaning the access is not consumed and the FSM stays put.
REQ-030 All outputs except instr_count SHALL be decoded from the registered state only, with no combinational path from opcode to outputs.

Reset
REQ-031 rst=1 at a rising edge SHALL force state=IF, trap=0, instr_count=0 and latched opcode=0, regardless of hold, mem_ready or current state, including mid-instruction.
REQ-032 After reset, outputs SHALL be state=0, mem_req=1, mem_we=0, instr_done=0, trap=0 and instr_count=0.

Structure
REQ-033 Opcode values and state codes SHALL reside in the shared opcodes header; the state codes SHALL be added alongside the existing opcode macros.
REQ-034 The opcode-to-instruction-class decode SHALL be a single combinational sub-module, opcode_class_decode, instantiated once.
REQ-035 The FSM, opcode latch and counter SHALL reside in multicycle_control.

Verification
REQ-036 Reset, then ADD with mem_ready=1 -> states 0,1,3,5,0; instr_done high only in state 5; instr_count=1.
REQ-037 LD with mem_ready low for 2 cycles in LOAD4 -> states 0,1,7,8,8,8,10,0; mem_req=1 throughout LOAD4; instr_count +1.
REQ-038 STR, then change opcode to JUMP while in MEM_REF3 -> still goes to STORE4; mem_we=1 only there.
REQ-039 Undefined opcode in IF -> state 12 and trap=1 held for 10 cycles; rst -> state 0, trap=0, count=0.
REQ-040 hold=1 for 3 cycles in ALU_R3 -> state stays 3 with instr_done=0; completion is 3 cycles late.
REQ-041 CNT_W=2, five LDI -> instr_count sequence 1,2,3,0,1; rst asserted in LOAD4 -> state 0 on the next edge.
